// File: rtl/sodor5_verif_pkg.sv
// Shared types and defaults for the Sodor 5-stage retire-stream commit checker.
package sodor5_verif_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } retire_t;

    typedef enum logic {
        RUN,
        HALT
    } chk_state_e;

    localparam int unsigned DEFAULT_DEPTH   = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 64;

    // Writes to x0 are architecturally discarded, so only rd must agree there.
    function automatic logic retire_match(input retire_t a, input retire_t b);
        return (a.rd == b.rd) && ((a.rd == 5'd0) || (a.data == b.data));
    endfunction

endpackage

// File: rtl/sodor5_retire_fifo.sv
// Retire-entry FIFO with no backpressure; a push at full is dropped unless the
// same cycle also pops.
module sodor5_retire_fifo
    import sodor5_verif_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  logic    pop,
    input  retire_t din,
    output retire_t dout,
    output logic    empty,
    output logic    full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    retire_t     mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        do_push, do_pop;

    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = do_push ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d  = do_pop  ? (rptr_q + PTR_ONE) : rptr_q;
        dout    = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/sodor5_commit_checker.sv
// Lockstep retirement comparator: buffers core (A) and model (B) retire streams
// and reports first divergence, FIFO overflow and starvation as sticky flags.
module sodor5_commit_checker
    import sodor5_verif_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic [31:0] match_count,
    output logic        mismatch,
    output logic [4:0]  err_rd,
    output logic [31:0] err_a_data,
    output logic [31:0] err_b_data,
    output logic        overflow,
    output logic        timeout
);

    localparam int unsigned SW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [SW-1:0] TIMEOUT_W = SW'(TIMEOUT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    chk_state_e    state_q, state_d;
    logic [31:0]   count_q, count_d;
    logic          mism_q, mism_d;
    logic [4:0]    err_rd_q, err_rd_d;
    logic [31:0]   err_a_q, err_a_d;
    logic [31:0]   err_b_q, err_b_d;
    logic          ovf_q, ovf_d;
    logic          to_q, to_d;
    logic [SW-1:0] starve_q, starve_d;

    retire_t a_din, b_din, a_head, b_head;
    logic    a_empty, a_full, b_empty, b_full;
    logic    pop;

    assign a_din = '{rd: a_rd, data: a_data};
    assign b_din = '{rd: b_rd, data: b_data};

    sodor5_retire_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (a_valid),
        .pop     (pop),
        .din     (a_din),
        .dout    (a_head),
        .empty   (a_empty),
        .full    (a_full)
    );

    sodor5_retire_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (b_valid),
        .pop     (pop),
        .din     (b_din),
        .dout    (b_head),
        .empty   (b_empty),
        .full    (b_full)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mism_d   = mism_q;
        err_rd_d = err_rd_q;
        err_a_d  = err_a_q;
        err_b_d  = err_b_q;
        to_d     = to_q;
        starve_d = starve_q;
        pop      = 1'b0;

        case (state_q)
            RUN: begin
                if (!a_empty && !b_empty) begin
                    pop      = 1'b1;
                    starve_d = '0;
                    if (retire_match(a_head, b_head)) begin
                        count_d = count_q + 32'd1;
                    end else begin
                        mism_d   = 1'b1;
                        err_rd_d = a_head.rd;
                        err_a_d  = a_head.data;
                        err_b_d  = b_head.data;
                        state_d  = HALT;
                    end
                end else if (a_empty && b_empty) begin
                    starve_d = '0;
                end else if (starve_q != '1) begin
                    starve_d = starve_q + STARVE_ONE;
                end
                if (starve_d >= TIMEOUT_W) begin
                    to_d = 1'b1;
                end
            end
            default: ;
        endcase

        // A pop in the same cycle frees the slot, so only an unmatched push at full is lost.
        ovf_d = ovf_q | (a_valid & a_full & ~pop) | (b_valid & b_full & ~pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            count_q  <= '0;
            mism_q   <= 1'b0;
            err_rd_q <= '0;
            err_a_q  <= '0;
            err_b_q  <= '0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mism_q   <= mism_d;
            err_rd_q <= err_rd_d;
            err_a_q  <= err_a_d;
            err_b_q  <= err_b_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
            starve_q <= starve_d;
        end
    end

    assign match_count = count_q;
    assign mismatch    = mism_q;
    assign err_rd      = err_rd_q;
    assign err_a_data  = err_a_q;
    assign err_b_data  = err_b_q;
    assign overflow    = ovf_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_sodor5_commit_checker.sv
// Directed self-checking bench for sodor5_commit_checker (DEPTH=8, TIMEOUT=64).
module tb_sodor5_commit_checker;

    logic        clk;
    logic        reset_n;
    logic        a_valid, b_valid;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic [31:0] match_count;
    logic        mismatch;
    logic [4:0]  err_rd;
    logic [31:0] err_a_data, err_b_data;
    logic        overflow, timeout;

    int pass_cnt;
    int total_cnt;

    sodor5_commit_checker #(.DEPTH(8), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a_valid     (a_valid),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .match_count (match_count),
        .mismatch    (mismatch),
        .err_rd      (err_rd),
        .err_a_data  (err_a_data),
        .err_b_data  (err_b_data),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bdata;
        logic [31:0] exp_cnt;
        logic        exp_mism;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        tick();
    endtask

    function automatic logic [127:0] all_outs();
        return {match_count, mismatch, err_rd, err_a_data, err_b_data, overflow, timeout};
    endfunction

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset_n   = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Aligned matches, x0 rule and a short skew; expected state after each edge.
        vecs[0]  = '{1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, 32'h1234, 32'd0, 1'b0};
        vecs[1]  = '{1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, 32'h1234, 32'd1, 1'b0};
        vecs[2]  = '{1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, 32'h1234, 32'd2, 1'b0};
        vecs[3]  = '{1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, 32'h1234, 32'd3, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    32'd4, 1'b0};
        vecs[5]  = '{1'b1, 5'd0, 32'h5,    1'b1, 5'd0, 32'h9,    32'd4, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    32'd5, 1'b0};
        vecs[7]  = '{1'b1, 5'd1, 32'h11,   1'b0, 5'd0, 32'h0,    32'd5, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    32'd5, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd1, 32'h11,   32'd5, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    32'd6, 1'b0};

        #12 reset_n = 1'b1;
        #1;
        chk("reset_outputs", all_outs(), 128'd0);
        tick();

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].bv, vecs[i].brd, vecs[i].bdata);
            tick();
            chk($sformatf("vec%0d", i), {match_count, mismatch, overflow, timeout},
                {vecs[i].exp_cnt, vecs[i].exp_mism, 2'b00});
        end

        // Skewed match: B trails A by 5 cycles.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd4, 32'h40 + i, 1'b0, 5'd0, 32'd0);
            tick();
        end
        idle(2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h40 + i);
            tick();
        end
        idle(2);
        chk("skew_count", match_count, 32'd3);
        chk("skew_flags", {mismatch, overflow, timeout}, 3'b000);

        // Data mismatch, then HALT freezes the counter.
        do_reset();
        drive(1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'hAAAA0001);
        tick();
        idle(1);
        chk("mism_capture", {mismatch, err_rd, err_a_data, err_b_data},
            {1'b1, 5'd7, 32'hAAAA0000, 32'hAAAA0001});
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd3, 32'h77, 1'b1, 5'd3, 32'h77);
            tick();
        end
        idle(2);
        chk("halt_frozen", {match_count, mismatch, err_rd, err_a_data, err_b_data},
            {32'd0, 1'b1, 5'd7, 32'hAAAA0000, 32'hAAAA0001});

        // Overflow at DEPTH+1 pushes, timeout exactly 64 edges after the first push.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'd2, 32'h100 + i, 1'b0, 5'd0, 32'd0);
            tick();
        end
        chk("full_no_ovf", overflow, 1'b0);
        drive(1'b1, 5'd2, 32'h108, 1'b0, 5'd0, 32'd0);
        tick();
        chk("overflow", overflow, 1'b1);
        idle(55);
        chk("timeout_early", timeout, 1'b0);
        idle(1);
        chk("timeout_exact", {timeout, mismatch, match_count}, {1'b1, 1'b0, 32'd0});

        // Async reset mid-stream discards buffered entries.
        do_reset();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h99);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd2, 32'h22 + i, 1'b0, 5'd0, 32'd0);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("pre_reset_count", match_count, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset", all_outs(), 128'd0);
        #2 reset_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 32'h33);
            tick();
        end
        idle(2);
        chk("post_reset", {match_count, mismatch, overflow, timeout}, {32'd2, 3'b000});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sodor5_commit_checker.md
# sodor5_commit_checker

Lockstep retirement comparator for the Sodor 5-stage verification harness. It takes the register-writeback retire stream from the RTL core (side A) and from the reference model (side B), buffers each stream in its own FIFO to absorb pipeline-latency skew, and compares the streams in order. It reports the first divergence, FIFO overflow and stream starvation as sticky flags. It sits in `sodor5_verif` next to the instruction driver and consumes what that driver's instructions produce.

## Interface
Parameters:
- `DEPTH`, 8: entries per side FIFO; must be a power of 2, ≥2.
- `TIMEOUT`, 64: cycles one side may hold entries while the other is empty before `timeout` is raised.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  RTL core retires a register write this cycle.
- `a_rd`  in  5  destination register of the side-A retire.
- `a_data`  in  32  writeback value of the side-A retire.
- `b_valid`  in  1  model retires a register write this cycle.
- `b_rd`  in  5  destination register of the side-B retire.
- `b_data`  in  32  writeback value of the side-B retire.
- `match_count`  out  32  number of compared pairs that matched.
- `mismatch`  out  1  sticky; set on the first divergence.
- `err_rd`  out  5  side-A `rd` of the first mismatching pair.
- `err_a_data`  out  32  side-A data of the first mismatching pair.
- `err_b_data`  out  32  side-B data of the first mismatching pair.
- `overflow`  out  1  sticky; a push arrived at a full FIFO.
- `timeout`  out  1  sticky; starvation limit reached.

## Operation
- Each side has its own FIFO. `x_valid` pushes `{rd,data}`. There is no backpressure.
- Push at a full FIFO:
  - The entry is dropped and `overflow` is set.
  - Exception: a push in the same cycle as a pop of that FIFO is accepted.
- FSM states:
  - RUN: when both FIFOs are non-empty, pop both heads in the same cycle and compare them.
  - The pair matches when `rd` is equal AND (`rd`==0 OR `data` is equal).
  - Match: `match_count`++, and the counter wraps at 2^32.
  - Mismatch: capture `err_*`, set `mismatch`, go to HALT.
  - HALT: no pops and no compares. Pushes continue and may set `overflow`. The counter freezes. HALT is left only by reset.
- Starvation counter, 8+ bits wide, saturating:
  - Increments each RUN cycle in which exactly one FIFO is non-empty.
  - Clears when a compare happens, or when both FIFOs are empty.
  - Reaching `TIMEOUT` sets `timeout`. The FSM stays in RUN.
- Reset values:
  - All outputs 0.
  - FIFOs empty, FSM in RUN, starvation counter 0.
  - Reset assertion in the middle of operation discards all buffered entries immediately (asynchronous).

## Timing
- Compare is combinational on the FIFO heads.
- Pop, counter update, error capture and flag setting all occur at the same rising edge. The results are visible on the outputs on the next cycle.
- Minimum latency, both sides pushing in the same cycle: push at edge N, compare and pop at edge N+1, `match_count`/`mismatch` update visible after edge N+1.
- FIFO occupancy is DEPTH-bounded. Pointers are log2(DEPTH)+1 bits wide and wrap naturally. Full when the MSBs differ and the lower bits are equal.

## Structure
- `sodor5_verif_pkg` holds:
  - the `retire_t` struct `{logic [4:0] rd; logic [31:0] data;}`;
  - the `chk_state_e` enum `{RUN, HALT}`;
  - the default `DEPTH`/`TIMEOUT` constants.
- One sub-module, `sodor5_retire_fifo`, is instantiated twice. It is parameterised by `DEPTH`. Its ports are `push`, `pop`, `din`/`dout` of type `retire_t`, `empty` and `full`. Its reset is asynchronous and active-low.

## Test plan
1. Aligned match: both sides push (rd=5, 0x1234) on the same cycle, 4 times → `match_count`=4, no flags set.
2. Skewed match: A pushes 3 entries; B pushes the same 3 entries starting 5 cycles later → `match_count`=3, `timeout`=0 with `TIMEOUT`=64.
3. Data mismatch: A (rd=7, 0xAAAA0000), B (rd=7, 0xAAAA0001) → `mismatch`=1, `err_rd`=7, `err_a_data`=0xAAAA0000, `err_b_data`=0xAAAA0001. Further matching pairs leave `match_count` frozen.
4. x0 rule: A (rd=0, 0x5), B (rd=0, 0x9) → counts as a match, `mismatch`=0.
5. Overflow and timeout: A pushes DEPTH+1 entries, B idle → `overflow`=1; `timeout`=1 exactly `TIMEOUT` cycles after A's first push was registered.
6. Async reset mid-stream with 3 entries buffered → all outputs 0 immediately. Subsequent aligned pairs compare from empty FIFOs, with no stale entries.
